// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/subtract engine with valid/ready operand and result handshakes
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  res_reg;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;
    logic s_bit;
    logic carry_nxt;

    // One full-adder slice on the operand LSBs, built from two half adders.
    assign ha1_s     = a_reg[0] ^ b_reg[0];
    assign ha1_c     = a_reg[0] & b_reg[0];
    assign s_bit     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;

    // Handshake outputs depend on state only, so no input reaches them combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B here and seed the carry with op.
                        a_reg <= a;
                        b_reg <= b ^ {WIDTH{op}};
                        carry <= op;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    res_reg <= {s_bit, res_reg[WIDTH-1:1]};
                    carry   <= carry_nxt;
                    cnt     <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign sum  = res_reg;
    assign cout = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - table-driven scoreboard bench for serial_add_ctrl
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] es;
        logic         ec;
        int           hold;
        bit           mess;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[9];
    int   tests  = 0;
    int   failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
        logic [W:0] t;
        exp_t   r;
        if (o) t = {1'b0, x} - {1'b0, y};
        else   t = {1'b0, x} + {1'b0, y};
        r.sum  = t[W-1:0];
        r.cout = o ? (x >= y) : t[W];
        return r;
    endfunction

    // Runs one operation starting at a negedge; returns at the negedge of the first IDLE cycle after DONE.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xo,
                          input exp_t e, input int hold, input bit mess, output int acc);
        int   n;
        int   lat;
        int   busy_cnt;
        exp_t got;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        a = xa; b = xb; op = xo; in_valid = 1'b1;
        acc = cyc;
        exp_q.push_back(e);
        lat = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mess) begin
                in_valid  = 1'b1;
                a         = W'($urandom);
                b         = W'($urandom);
                op        = 1'($urandom);
                out_ready = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (busy) busy_cnt++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check("out_valid_latency", lat, W + 1);
        check("busy_cycles", busy_cnt, W);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            got = exp_q.pop_front();
            check("sum", sum, got.sum);
            check("cout", cout, got.cout);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("hold_out_valid", out_valid, 1);
                check("hold_sum", sum, got.sum);
                check("hold_cout", cout, got.cout);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int   acc;
        int   prev_acc;
        int   prev_hold;
        int   seen;
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         ro;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 0, 1'b0};
        vecs[3] = '{8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 5, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, 1'b0};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 0, 1'b0};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 2, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 0, 1'b1};
        vecs[8] = '{8'h3C, 8'hC3, 1'b1, 8'h79, 1'b0, 0, 1'b0};

        rst = 1'b1; in_valid = 1'b1; a = 8'h5A; b = 8'hA5; op = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);

        prev_acc = 0;
        prev_hold = 1;
        for (int i = 0; i < 9; i++) begin
            e.sum  = vecs[i].es;
            e.cout = vecs[i].ec;
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, e, vecs[i].hold, vecs[i].mess, acc);
            if (i > 0 && prev_hold == 0) check("op_spacing", acc - prev_acc, W + 2);
            prev_acc  = acc;
            prev_hold = vecs[i].hold;
        end

        // Reset mid-RUN discards the operation.
        a = 8'h12; b = 8'h34; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_cout", cout, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrun_rst_no_out_valid", seen, 0);

        // in_valid during a reset cycle is not accepted.
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_cycle_not_accepted", busy, 0);

        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ro = 1'($urandom);
            run_op(ra, rb, ro, model(ra, rb, ro), int'($urandom_range(0, 2)), 1'b0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; the legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port op, input, 1 bit: 0 = A+B, 1 = A-B.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB; for op=1 it means no-borrow.
REQ-013 The block SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-014 The block SHALL have three FSM states: IDLE, RUN and DONE, all state-registered.
REQ-015 In IDLE the block SHALL drive in_ready=1; in RUN and DONE it SHALL drive in_ready=0.
REQ-016 The block SHALL accept operands when in_valid and in_ready are both high in cycle T: latch a, b XOR {WIDTH{op}}, and carry = op; clear the bit counter; go to RUN at T+1.
REQ-017 Each RUN cycle SHALL process one bit, LSB first, through one full-adder slice built from two half adders plus an OR: s_bit = a0^b0^carry, carry' = a0&b0 | (a0^b0)&carry.
REQ-018 Each RUN cycle SHALL shift s_bit into the result register MSB and shift the operand registers right by one.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH)) bits wide; RUN SHALL last exactly WIDTH cycles, and the cycle with counter==WIDTH-1 SHALL go to DONE.
REQ-020 In DONE the block SHALL drive out_valid=1, sum = the full result, and cout = the final carry.
REQ-021 The first cycle with out_valid=1 SHALL be T+WIDTH+1.
REQ-022 In DONE with out_valid and out_ready both high, the block SHALL go to IDLE next cycle; with out_ready low it SHALL stay in DONE, holding sum and cout stable indefinitely.
REQ-023 Results SHALL be modulo 2^WIDTH: op=1 computes A + ~B + 1, and cout=1 iff A>=B unsigned.
REQ-024 in_valid asserted in RUN or DONE SHALL be ignored, with no effect on operands or state; operand inputs are sampled only in the accept cycle.
REQ-025 A new operation SHALL begin no earlier than the cycle after DONE exits, giving a minimum period of WIDTH+2 cycles per operation.
REQ-026 out_ready asserted outside DONE SHALL have no effect.
REQ-027 The block SHALL NOT pass combinational paths from any input to in_ready or out_valid.

Reset
REQ-028 With rst high at a clock edge, the next state SHALL be IDLE and the outputs SHALL be in_ready=1, out_valid=0, busy=0, sum=0, cout=0; the internal carry and counter SHALL be 0.
REQ-029 rst SHALL take priority over all handshakes; reset in RUN or DONE SHALL discard the operation in flight with no out_valid pulse.
REQ-030 in_valid high in the reset cycle SHALL NOT be accepted.

Verification (WIDTH=8)
REQ-031 The bench SHALL cover: a=0x0F, b=0x01, op=0 accepted at T -> busy T+1..T+8, out_valid at T+9, sum=0x10, cout=0.
REQ-032 The bench SHALL cover: a=0xFF, b=0x01, op=0 -> sum=0x00, cout=1.
REQ-033 The bench SHALL cover: a=0x05, b=0x07, op=1 -> sum=0xFE, cout=0; and a=0x07, b=0x05, op=1 -> sum=0x02, cout=1.
REQ-034 The bench SHALL cover: out_ready held low 5 cycles after out_valid -> sum, cout and out_valid stable; the first out_ready high -> IDLE next cycle with in_ready=1.
REQ-035 The bench SHALL cover: rst pulsed at T+4 mid-RUN -> IDLE with in_ready=1, sum=0, and no out_valid; a following op completes correctly.
REQ-036 The bench SHALL cover: in_valid held high with changing a during RUN -> result reflects only the operands from the accept cycle; back-to-back ops spaced WIDTH+2 cycles apart.
